// File: rtl/bench_poll_master.sv
// AXI4-Lite master that starts a benchmark, polls STATUS until done, then reads the result words.
// Define BENCH_POLL_MASTER_CLEAR_EN to issue a soft_clear write after the final result read.
module bench_poll_master #(
    parameter int POLL_GAP   = 16,
    parameter int POLL_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    output logic        busy,
    output logic        done_pulse,
    output logic [1:0]  err,
    output logic [31:0] t_cond0,
    output logic [31:0] t_cond1,
    output logic [31:0] t_cond2,
    output logic [31:0] t_cond3,
    output logic [1:0]  winner_code,
    output logic [3:0]  win_onehot,
    output logic [5:0]  m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [5:0]  m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, GAP, RD_ADDR, RD_DATA, FINISH} state_t;

    localparam logic [5:0] A_CONTROL = 6'h00;
    localparam logic [5:0] A_STATUS  = 6'h04;
    localparam logic [5:0] A_TCOND0  = 6'h08;
    localparam logic [2:0] IDX_WIN   = 3'd5;

    state_t state, state_nxt;

    logic             aw_pend, w_pend;
    logic [7:0]       gap_cnt;
    logic [16:0]      poll_cnt;
    logic [2:0]       rd_idx;      // 0 = STATUS, 1..4 = TCOND0..3, 5 = WIN_ONEHOT
    logic             clr_wr;      // current write is the soft_clear, not the start
    logic [3:0][31:0] t_cond;

    logic wr_done, gap_end, poll_last, st_done;

    assign wr_done   = (!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready);
    assign gap_end   = gap_cnt == 8'(POLL_GAP - 1);
    assign poll_last = (poll_cnt + 17'd1) == 17'(POLL_LIMIT);
    assign st_done   = m_axi_rdata[1];

    assign m_axi_awvalid = aw_pend;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_bready  = state == WR_RESP;
    assign m_axi_arvalid = state == RD_ADDR;
    assign m_axi_rready  = state == RD_DATA;
    assign busy          = state != IDLE;
    assign done_pulse    = state == FINISH;
    assign t_cond0       = t_cond[0];
    assign t_cond1       = t_cond[1];
    assign t_cond2       = t_cond[2];
    assign t_cond3       = t_cond[3];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_start) state_nxt = WR_ADDR;
            WR_ADDR: if (wr_done) state_nxt = WR_RESP;
            WR_RESP: if (m_axi_bvalid)
                         state_nxt = (m_axi_bresp != 2'b00 || clr_wr) ? FINISH : GAP;
            GAP:     if (gap_end) state_nxt = RD_ADDR;
            RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axi_rvalid) begin
                if (m_axi_rresp != 2'b00)  state_nxt = FINISH;
                else if (rd_idx == 3'd0)   state_nxt = st_done ? RD_ADDR : (poll_last ? FINISH : GAP);
                else if (rd_idx != IDX_WIN) state_nxt = RD_ADDR;
                else begin
`ifdef BENCH_POLL_MASTER_CLEAR_EN
                    state_nxt = WR_ADDR;
`else
                    state_nxt = FINISH;
`endif
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_pend      <= 1'b0;
            w_pend       <= 1'b0;
            m_axi_awaddr <= '0;
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
            m_axi_araddr <= '0;
            gap_cnt      <= '0;
            poll_cnt     <= '0;
            rd_idx       <= '0;
            clr_wr       <= 1'b0;
            err          <= '0;
            t_cond       <= '0;
            winner_code  <= '0;
            win_onehot   <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_start) begin
                    aw_pend      <= 1'b1;
                    w_pend       <= 1'b1;
                    m_axi_awaddr <= A_CONTROL;
                    m_axi_wdata  <= 32'h0000_0001;
                    m_axi_wstrb  <= 4'hF;
                    clr_wr       <= 1'b0;
                    poll_cnt     <= '0;
                    err          <= '0;
                    t_cond       <= '0;
                    winner_code  <= '0;
                    win_onehot   <= '0;
                end
                // each valid falls on its own handshake; order between AW and W is free
                WR_ADDR: begin
                    if (m_axi_awready) aw_pend <= 1'b0;
                    if (m_axi_wready)  w_pend  <= 1'b0;
                end
                WR_RESP: begin
                    gap_cnt <= '0;
                    if (m_axi_bvalid && m_axi_bresp != 2'b00) err <= 2'd1;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_end) begin
                        m_axi_araddr <= A_STATUS;
                        rd_idx       <= 3'd0;
                    end
                end
                RD_DATA: if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) begin
                        err <= 2'd2;
                    end else if (rd_idx == 3'd0) begin
                        if (st_done) begin
                            winner_code  <= m_axi_rdata[3:2];
                            rd_idx       <= 3'd1;
                            m_axi_araddr <= A_TCOND0;
                        end else begin
                            poll_cnt <= poll_cnt + 17'd1;
                            gap_cnt  <= '0;
                            if (poll_last) err <= 2'd3;
                        end
                    end else if (rd_idx != IDX_WIN) begin
                        t_cond[2'(rd_idx - 3'd1)] <= m_axi_rdata;
                        rd_idx       <= rd_idx + 3'd1;
                        m_axi_araddr <= m_axi_araddr + 6'd4;
                    end else begin
                        win_onehot <= m_axi_rdata[3:0];
`ifdef BENCH_POLL_MASTER_CLEAR_EN
                        aw_pend      <= 1'b1;
                        w_pend       <= 1'b1;
                        m_axi_awaddr <= A_CONTROL;
                        m_axi_wdata  <= 32'h0000_0002;
                        m_axi_wstrb  <= 4'hF;
                        clr_wr       <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bench_poll_master.sv
// Randomized bench: reactive AXI4-Lite slave plus a sequence-level model of the expected transactions.
module tb_bench_poll_master;
    localparam int GAP   = 3;
    localparam int LIMIT = 4;

    logic        clk = 1'b0, rst = 1'b1, cmd_start = 1'b0;
    logic        busy, done_pulse;
    logic [1:0]  err, winner_code;
    logic [31:0] t_cond0, t_cond1, t_cond2, t_cond3;
    logic [3:0]  win_onehot;
    logic [5:0]  m_axi_awaddr, m_axi_araddr;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0, m_axi_rvalid = 0;
    logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
    logic [31:0] m_axi_rdata = 0;

    always #5 clk = ~clk;

    bench_poll_master #(.POLL_GAP(GAP), .POLL_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .done_pulse(done_pulse), .err(err),
        .t_cond0(t_cond0), .t_cond1(t_cond1), .t_cond2(t_cond2), .t_cond3(t_cond3),
        .winner_code(winner_code), .win_onehot(win_onehot),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // slave configuration and register contents
    int          cfg_d, cfg_bad_w, cfg_bad_r, cfg_dly, cfg_awd, cfg_wd;
    logic [31:0] sv_tc[4];
    logic [1:0]  sv_win;
    logic [31:0] sv_oh;

    // slave state and observation logs
    int          n_status, n_wr, n_rd, viol, gap_bad;
    int          cyc = 0, last_cyc, last_kind, last_b_cyc, last_done_cyc;
    logic [5:0]  rd_log[$];
    logic [41:0] wr_log[$];
    bit          aw_got, w_got, b_pend, r_pend, aw_arm, w_arm, ar_arm, dn;
    bit          prev_aw, prev_w, prev_ar, prev_arv;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait, aw_dly, w_dly, ar_dly, b_dly, r_dly, r_kind;
    logic [5:0]  p_awaddr, p_araddr, w_addr_q;
    logic [35:0] p_wd, w_data_q;
    logic [1:0]  b_resp_q, r_resp_q;
    logic [31:0] r_data_q;

    function automatic int pick(input int f);
        return f >= 0 ? f : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] reg_val(input logic [5:0] a, input bit d);
        case (a)
            6'h04:   return {28'h0, sv_win, d, !d};
            6'h08:   return sv_tc[0];
            6'h0C:   return sv_tc[1];
            6'h10:   return sv_tc[2];
            6'h14:   return sv_tc[3];
            6'h18:   return sv_oh;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Slave decides ready/valid at each falling edge; handshakes take effect on the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (done_pulse) last_done_cyc = cyc;
        if (rst) begin
            {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
            m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rdata = '0;
            {aw_got, w_got, b_pend, r_pend, aw_arm, w_arm, ar_arm} = '0;
            {prev_aw, prev_w, prev_ar, prev_arv} = '0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0; last_kind = 0;
        end else begin
            if (prev_aw && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
            if (prev_w && (!m_axi_wvalid || {m_axi_wdata, m_axi_wstrb} != p_wd)) viol++;
            if (prev_ar && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
            if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready)) viol++;
            if (m_axi_arvalid && (aw_got || w_got || b_pend || r_pend)) viol++;
            if ((m_axi_awvalid || m_axi_wvalid) && (b_pend || r_pend)) viol++;
            if (m_axi_arvalid && !prev_arv && last_kind != 0) begin
                if (cyc - last_cyc != (last_kind == 2 ? GAP + 1 : 1)) gap_bad++;
                last_kind = 0;
            end
            prev_arv = m_axi_arvalid;

            if (m_axi_awvalid && !aw_arm) begin aw_dly = pick(cfg_awd >= 0 ? cfg_awd : cfg_dly); aw_arm = 1; end
            if (m_axi_wvalid && !w_arm)   begin w_dly = pick(cfg_wd >= 0 ? cfg_wd : cfg_dly);    w_arm = 1;  end
            if (m_axi_arvalid && !ar_arm) begin ar_dly = pick(cfg_dly); ar_arm = 1; end
            m_axi_awready = m_axi_awvalid && !aw_got && aw_wait >= aw_dly;
            m_axi_wready  = m_axi_wvalid && !w_got && w_wait >= w_dly;
            m_axi_bvalid  = b_pend && b_wait >= b_dly;
            m_axi_bresp   = m_axi_bvalid ? b_resp_q : 2'b00;
            m_axi_arready = m_axi_arvalid && !r_pend && ar_wait >= ar_dly;
            m_axi_rvalid  = r_pend && r_wait >= r_dly;
            m_axi_rresp   = m_axi_rvalid ? r_resp_q : 2'b00;
            m_axi_rdata   = m_axi_rvalid ? r_data_q : 32'h0;

            prev_aw = m_axi_awvalid && !m_axi_awready; p_awaddr = m_axi_awaddr;
            prev_w  = m_axi_wvalid && !m_axi_wready;   p_wd = {m_axi_wdata, m_axi_wstrb};
            prev_ar = m_axi_arvalid && !m_axi_arready; p_araddr = m_axi_araddr;

            if (m_axi_bvalid && m_axi_bready) begin
                b_pend = 0; last_b_cyc = cyc; last_cyc = cyc; last_kind = (b_resp_q == 0) ? 2 : 0;
            end else if (b_pend) b_wait++;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_got = 1; aw_arm = 0; aw_wait = 0; w_addr_q = m_axi_awaddr;
            end else if (m_axi_awvalid) aw_wait++;
            if (m_axi_wvalid && m_axi_wready) begin
                w_got = 1; w_arm = 0; w_wait = 0; w_data_q = {m_axi_wdata, m_axi_wstrb};
            end else if (m_axi_wvalid) w_wait++;
            if (aw_got && w_got) begin
                wr_log.push_back({w_addr_q, w_data_q});
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0; b_dly = pick(cfg_dly);
                b_resp_q = (n_wr == cfg_bad_w) ? 2'd2 : 2'd0;
                n_wr++;
            end

            if (m_axi_rvalid && m_axi_rready) begin
                r_pend = 0; last_cyc = cyc; last_kind = r_kind;
            end else if (r_pend) r_wait++;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_arm = 0; ar_wait = 0;
                rd_log.push_back(m_axi_araddr);
                dn = 0;
                if (m_axi_araddr == 6'h04) begin n_status++; dn = n_status >= cfg_d; end
                r_data_q = reg_val(m_axi_araddr, dn);
                r_resp_q = (n_rd == cfg_bad_r) ? 2'd2 : 2'd0;
                n_rd++;
                r_kind = (r_resp_q != 0) ? 0 : (m_axi_araddr == 6'h04 && !dn) ? 2 : 1;
                r_pend = 1; r_wait = 0; r_dly = pick(cfg_dly);
            end else if (m_axi_arvalid) ar_wait++;
        end
    end

    task automatic check_zero(input string nm);
        chk({nm, "/ctl"}, {busy, done_pulse, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready, winner_code, win_onehot,
                           m_axi_awaddr, m_axi_araddr, m_axi_wstrb}, 64'h0);
        chk({nm, "/dat0"}, {m_axi_wdata, t_cond0}, 64'h0);
        chk({nm, "/dat1"}, {t_cond1, t_cond2}, 64'h0);
        chk({nm, "/dat2"}, {32'h0, t_cond3}, 64'h0);
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 4; i++) sv_tc[i] = $urandom;
        sv_win = 2'($urandom_range(0, 3));
        sv_oh  = $urandom;
    endtask

    task automatic run(input string nm, input int d, input int bw, input int br,
                       input int dly, input int awd, input int wd);
        logic [5:0]  e_rd[$];
        logic [41:0] e_wr[$];
        logic [1:0]  e_err, e_win;
        logic [31:0] e_tc[4];
        logic [3:0]  e_oh;
        bit          done_seen, stop;
        int          ndone, busy_bad, mm;

        // expected transaction sequence from the benchmark rules
        e_err = 0; e_win = 0; e_oh = 0; done_seen = 0; stop = 0;
        for (int i = 0; i < 4; i++) e_tc[i] = 0;
        e_wr.push_back({6'h00, 32'h1, 4'hF});
        if (bw == 0) e_err = 1;
        else begin
            for (int p = 1; p <= LIMIT && !stop; p++) begin
                e_rd.push_back(6'h04);
                if (e_rd.size() - 1 == br) begin e_err = 2; stop = 1; end
                else if (p >= d) begin done_seen = 1; e_win = sv_win; stop = 1; end
                else if (p == LIMIT) e_err = 3;
            end
            if (done_seen) begin
                stop = 0;
                for (int j = 0; j < 5 && !stop; j++) begin
                    e_rd.push_back(6'(8 + 4 * j));
                    if (e_rd.size() - 1 == br) begin e_err = 2; stop = 1; end
                    else if (j < 4) e_tc[j] = sv_tc[j];
                    else e_oh = sv_oh[3:0];
                end
`ifdef BENCH_POLL_MASTER_CLEAR_EN
                if (e_err == 0) begin
                    e_wr.push_back({6'h00, 32'h2, 4'hF});
                    if (bw == 1) e_err = 1;
                end
`endif
            end
        end

        cfg_d = d; cfg_bad_w = bw; cfg_bad_r = br; cfg_dly = dly; cfg_awd = awd; cfg_wd = wd;
        n_status = 0; n_wr = 0; n_rd = 0; viol = 0; gap_bad = 0;
        rd_log.delete(); wr_log.delete();

        @(negedge clk) cmd_start = 1;
        @(negedge clk) cmd_start = 0;
        ndone = 0; busy_bad = 0; stop = 0;
        for (int i = 0; i < 4000 && !stop; i++) begin
            if (done_pulse) begin
                ndone++; stop = 1;
                cmd_start = 1;           // coincides with done_pulse: must be ignored
            end else begin
                if (!busy) busy_bad++;
                cmd_start = ($urandom_range(0, 5) == 0);   // busy: must be ignored
                @(negedge clk);
            end
        end
        chk({nm, "/timeout"}, stop, 1);
        @(negedge clk) cmd_start = 0;
        chk({nm, "/busy_after"}, busy, 0);
        repeat (12) begin
            if (done_pulse) ndone++;
            @(negedge clk);
        end

        chk({nm, "/err"}, err, e_err);
        chk({nm, "/winner"}, winner_code, e_win);
        chk({nm, "/onehot"}, win_onehot, e_oh);
        chk({nm, "/tc01"}, {t_cond0, t_cond1}, {e_tc[0], e_tc[1]});
        chk({nm, "/tc23"}, {t_cond2, t_cond3}, {e_tc[2], e_tc[3]});
        chk({nm, "/ndone"}, ndone, 1);
        chk({nm, "/busy"}, busy_bad, 0);
        chk({nm, "/wr_n"}, wr_log.size(), e_wr.size());
        mm = 0;
        for (int i = 0; i < wr_log.size() && i < e_wr.size(); i++) if (wr_log[i] !== e_wr[i]) mm++;
        chk({nm, "/wr_log"}, mm, 0);
        chk({nm, "/rd_n"}, rd_log.size(), e_rd.size());
        mm = 0;
        for (int i = 0; i < rd_log.size() && i < e_rd.size(); i++) if (rd_log[i] !== e_rd[i]) mm++;
        chk({nm, "/rd_log"}, mm, 0);
        chk({nm, "/proto"}, viol, 0);
        chk({nm, "/gap"}, gap_bad, 0);
        if (bw == 0) chk({nm, "/done_lat"}, (last_done_cyc - last_b_cyc) <= 2, 1);
    endtask

    initial begin
        bit hit;
        rst = 1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0;

        sv_tc = '{32'h10, 32'h20, 32'h30, 32'h08}; sv_win = 2'd2; sv_oh = 32'h8;
        run("basic", 3, -1, -1, 0, -1, -1);
        rand_vals(); run("aw_first", 1, -1, -1, 0, 0, 3);
        rand_vals(); run("w_first", 2, -1, -1, 0, 3, 0);
        rand_vals(); run("bresp", 2, 0, -1, -1, -1, -1);
        rand_vals(); run("timeout", 10, -1, -1, -1, -1, -1);
        rand_vals(); run("rresp_st", 3, -1, 1, -1, -1, -1);
        rand_vals(); run("rresp_res", 1, -1, 3, -1, -1, -1);
        rand_vals(); run("clr_bresp", 1, 1, -1, -1, -1, -1);

        // reset while a read address is pending
        cfg_d = 5; cfg_bad_w = -1; cfg_bad_r = -1; cfg_dly = 8; cfg_awd = -1; cfg_wd = -1;
        @(negedge clk) cmd_start = 1;
        @(negedge clk) cmd_start = 0;
        hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (m_axi_arvalid) hit = 1;
            else @(negedge clk);
        end
        chk("rst_mid/arvalid", hit, 1);
        rst = 1;
        @(negedge clk);
        check_zero("rst_mid");
        rst = 0;
        rand_vals(); run("after_rst", 2, -1, -1, -1, -1, -1);

        for (int k = 0; k < 16; k++) begin
            int d, bw, br, r;
            d  = $urandom_range(1, 6);
            r  = $urandom_range(0, 7);
            bw = (r == 0) ? 0 : (r == 1) ? 1 : -1;
            br = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 8)) : -1;
            rand_vals();
            run($sformatf("rnd%0d", k), d, bw, br, -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
